// File: rtl/cpu_mc_pkg.sv
// Shared types and instruction-field constants for the multicycle 9-bit-ISA core.
package cpu_mc_pkg;

    localparam int INSTR_W = 9;
    localparam int FIELD_W = 3;
    localparam int OP_LSB  = 6;
    localparam int RA_LSB  = 3;
    localparam int RB_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_LD   = 3'd4,
        OP_ST   = 3'd5,
        OP_BNZ  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    function automatic logic [FIELD_W-1:0] fld(input logic [INSTR_W-1:0] ir, input int lsb);
        return ir[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// 8 x DW register file: two asynchronous read ports, one synchronous write port.
module cpu_mc_regfile
    import cpu_mc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [FIELD_W-1:0] i_raddr_a,
    input  logic [FIELD_W-1:0] i_raddr_b,
    output logic [DW-1:0]      o_rdata_a,
    output logic [DW-1:0]      o_rdata_b,
    input  logic               i_we,
    input  logic [FIELD_W-1:0] i_waddr,
    input  logic [DW-1:0]      i_wdata
);

    logic [DW-1:0] r_regs [8];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle core (fetch/decode/exec/mem/writeback) with Start/Ack handshake and req/valid data memory.
// Optional feature: define CPU_MC_CYCLE_COUNT_EN to build the CycleCt counter (otherwise tied to 0).
module cpu_multicycle
    import cpu_mc_pkg::*;
#(
    parameter int DW  = 16,
    parameter int PCW = 10,
    parameter int AW  = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    output logic               Ack,
    output logic [PCW-1:0]     imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [AW-1:0]      dmem_addr,
    output logic [DW-1:0]      dmem_wdata,
    input  logic [DW-1:0]      dmem_rdata,
    input  logic               dmem_rvalid,
    output logic [15:0]        CycleCt
);

    state_t               r_state;
    logic [PCW-1:0]       r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [DW-1:0]        r_a;
    logic [DW-1:0]        r_b;
    logic [DW-1:0]        r_res;
    logic                 r_ack;
    logic                 r_dreq;
    logic                 r_dwe;
    logic [AW-1:0]        r_daddr;
    logic [DW-1:0]        r_dwdata;

    opcode_t              w_op;
    logic [FIELD_W-1:0]   w_ra;
    logic [FIELD_W-1:0]   w_rb;
    logic [DW-1:0]        w_rd_a;
    logic [DW-1:0]        w_rd_b;
    logic [DW-1:0]        w_alu;
    logic                 w_rf_we;
    logic [PCW-1:0]       w_pc_inc;
    logic [PCW-1:0]       w_pc_br;

    assign w_op     = opcode_t'(fld(r_ir, OP_LSB));
    assign w_ra     = fld(r_ir, RA_LSB);
    assign w_rb     = fld(r_ir, RB_LSB);
    assign w_rf_we  = (r_state == S_WB) && (w_op != OP_ST);
    assign w_pc_inc = r_pc + PCW'(1);
    // rb doubles as the signed branch offset (-4..+3)
    assign w_pc_br  = r_pc + {{(PCW-FIELD_W){w_rb[FIELD_W-1]}}, w_rb};

    cpu_mc_regfile #(.DW(DW)) u_regfile (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
        .i_raddr_a (w_ra),
        .i_raddr_b (w_rb),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b),
        .i_we      (w_rf_we),
        .i_waddr   (w_ra),
        .i_wdata   (r_res)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_ack    <= 1'b0;
            r_dreq   <= 1'b0;
            r_dwe    <= 1'b0;
            r_daddr  <= '0;
            r_dwdata <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_pc    <= '0;
                        r_ack   <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= imem_rdata;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_a <= w_rd_a;
                    r_b <= w_rd_b;
                    if (w_op == OP_HALT) begin
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        OP_LD, OP_ST: begin
                            r_dreq   <= 1'b1;
                            r_dwe    <= (w_op == OP_ST);
                            r_daddr  <= r_b[AW-1:0];
                            r_dwdata <= r_a;
                            r_state  <= S_MEM;
                        end
                        OP_BNZ: begin
                            r_pc    <= (r_a != '0) ? w_pc_br : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        default: begin
                            r_res   <= w_alu;
                            r_state <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    // Memory outputs are cleared on exit so they read zero outside MEM
                    if (dmem_rvalid) begin
                        if (!r_dwe) r_res <= dmem_rdata;
                        r_dreq   <= 1'b0;
                        r_dwe    <= 1'b0;
                        r_daddr  <= '0;
                        r_dwdata <= '0;
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CPU_MC_CYCLE_COUNT_EN
    logic [15:0] r_cyc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cyc <= '0;
        end else if (r_state == S_IDLE || r_state == S_DONE) begin
            if (Start) r_cyc <= '0;
        end else if (r_cyc != 16'hFFFF) begin
            r_cyc <= r_cyc + 16'd1;
        end
    end

    assign CycleCt = r_cyc;
`else
    assign CycleCt = '0;
`endif

    assign Ack        = r_ack;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dreq;
    assign dmem_we    = r_dwe;
    assign dmem_addr  = r_daddr;
    assign dmem_wdata = r_dwdata;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: ROM and variable-latency data memory models, vector table plus corner sequences.
module tb_cpu_multicycle;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Ack;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [15:0] CycleCt;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          len;
        logic        stable;
    } access_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    logic [8:0]  rom [1024];
    logic [15:0] init_mem [256];
    logic [15:0] st_mem [256];
    int          st_epoch [256];
    int          epoch;
    int          ld_delay, st_delay;
    logic        resp_rv, late_rv;
    logic [15:0] rdata_r;
    access_t     acc_q [$];
    access_t     cur;
    int          cnt;
    int          taken;
    logic [9:0]  prev_pc;
    int          n_checks = 0;
    int          n_fail = 0;

    cpu_multicycle #(.DW(16), .PCW(10), .AW(8)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Ack         (Ack),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .CycleCt     (CycleCt)
    );

    always #5 Clk = ~Clk;

    assign imem_rdata  = rom[imem_addr];
    assign dmem_rdata  = rdata_r;
    assign dmem_rvalid = resp_rv | late_rv;

    function automatic logic [15:0] memval(input logic [7:0] a);
        return (st_epoch[a] == epoch) ? st_mem[a] : init_mem[a];
    endfunction

    function automatic int expc(input int n);
`ifdef CPU_MC_CYCLE_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Data memory responder: rvalid after ld_delay/st_delay extra cycles of req
    initial begin
        resp_rv = 1'b0;
        rdata_r = '0;
        cnt     = 0;
        forever begin
            @(negedge Clk);
            if (dmem_req) begin
                if (cnt == 0) begin
                    cur.we = dmem_we; cur.addr = dmem_addr; cur.wdata = dmem_wdata; cur.stable = 1'b1;
                end else if (cur.we !== dmem_we || cur.addr !== dmem_addr || cur.wdata !== dmem_wdata) begin
                    cur.stable = 1'b0;
                end
                if (cnt == (dmem_we ? st_delay : ld_delay)) begin
                    cur.len = cnt + 1;
                    if (dmem_we) begin
                        st_mem[dmem_addr]   = dmem_wdata;
                        st_epoch[dmem_addr] = epoch;
                        rdata_r = 16'hDEAD;
                    end else begin
                        rdata_r = memval(dmem_addr);
                    end
                    acc_q.push_back(cur);
                    cnt = 0;
                    resp_rv = 1'b1;
                end else begin
                    cnt++;
                    resp_rv = 1'b0;
                end
            end else begin
                cnt = 0;
                resp_rv = 1'b0;
            end
        end
    end

    initial begin
        taken = 0;
        prev_pc = '0;
        forever begin
            @(negedge Clk);
            if (prev_pc == 10'd3 && imem_addr == 10'd2) taken++;
            prev_pc = imem_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 9'o700;
    endtask

    task automatic new_mem();
        epoch++;
        for (int i = 0; i < 256; i++) init_mem[i] = '0;
    endtask

    task automatic start_prog();
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (Ack) break;
            @(negedge Clk);
        end
        check(name, {31'd0, Ack}, 32'd1);
    endtask

    vec_t vecs [6];
    int   base;

    initial begin
        vecs[0] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[1] = '{3'd0, 16'h1234, 16'h1111, 16'h2345};
        vecs[2] = '{3'd1, 16'h0005, 16'h0007, 16'hFFFE};
        vecs[3] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF};
        vecs[4] = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[5] = '{3'd3, 16'hFF00, 16'h0FF0, 16'hF0F0};

        Reset_n = 1'b0; Start = 1'b0; late_rv = 1'b0;
        ld_delay = 0; st_delay = 0; epoch = 1;
        clear_rom();
        new_mem();
        repeat (3) @(negedge Clk);
        check("rst_ack", {31'd0, Ack}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_daddr", {24'd0, dmem_addr}, 32'd0);
        check("rst_pc", {22'd0, imem_addr}, 32'd0);
        check("rst_cyc", {16'd0, CycleCt}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_ack", {31'd0, Ack}, 32'd0);

        // LD r1 <- 3, ADD r1,r1, HALT; then ST r1 to observe it
        new_mem(); init_mem[0] = 16'd3;
        clear_rom(); rom[0] = 9'o410; rom[1] = 9'o011; rom[2] = 9'o700;
        start_prog();
        wait_ack("t1_done");
        check("t1_cyc", {16'd0, CycleCt}, expc(11));
        check("t1_halt_pc", {22'd0, imem_addr}, 32'd2);
        clear_rom(); rom[0] = 9'o510; rom[1] = 9'o700;
        start_prog();
        wait_ack("t1b_done");
        check("t1_r1", {16'd0, memval(8'd0)}, 32'd6);

        // Countdown loop: r3=1, r2=5, SUB/BNZ -1 until zero
        base = taken;
        new_mem(); init_mem[0] = 16'd1; init_mem[1] = 16'd5;
        clear_rom();
        rom[0] = 9'o430; rom[1] = 9'o423; rom[2] = 9'o123;
        rom[3] = 9'o627; rom[4] = 9'o523; rom[5] = 9'o700;
        start_prog();
        wait_ack("t2_done");
        check("t2_r2", {16'd0, memval(8'd1)}, 32'd0);
        check("t2_taken", taken - base, 32'd4);
        check("t2_cyc", {16'd0, CycleCt}, expc(52));

        // ALU vector table: r1=mem[1], r2=mem[2], r1 op= r2, result to mem[4]
        for (int i = 0; i < 6; i++) begin
            new_mem();
            init_mem[0] = 16'd1; init_mem[1] = vecs[i].a; init_mem[2] = vecs[i].b;
            clear_rom();
            rom[0] = 9'o470; rom[1] = 9'o417; rom[2] = 9'o077; rom[3] = 9'o427;
            rom[4] = {vecs[i].op, 3'd1, 3'd2};
            rom[5] = 9'o077; rom[6] = 9'o517; rom[7] = 9'o700;
            start_prog();
            wait_ack($sformatf("alu%0d_done", i));
            check($sformatf("alu%0d_res", i), {16'd0, memval(8'd4)}, {16'd0, vecs[i].exp});
            check($sformatf("alu%0d_cyc", i), {16'd0, CycleCt}, expc(34));
        end

        // Store with rvalid delayed 3 cycles; store must not write the register file
        new_mem(); init_mem[0] = 16'h0012; init_mem[8'h12] = 16'h00AB;
        st_delay = 3;
        base = acc_q.size();
        clear_rom();
        rom[0] = 9'o450; rom[1] = 9'o445; rom[2] = 9'o044;
        rom[3] = 9'o545; rom[4] = 9'o540; rom[5] = 9'o700;
        start_prog();
        wait_ack("t4_done");
        st_delay = 0;
        check("t4_nacc", acc_q.size() - base, 32'd4);
        if (acc_q.size() >= base + 3) begin
            check("t4_st_len", acc_q[base+2].len, 32'd4);
            check("t4_st_we", {31'd0, acc_q[base+2].we}, 32'd1);
            check("t4_st_addr", {24'd0, acc_q[base+2].addr}, 32'h12);
            check("t4_st_wdata", {16'd0, acc_q[base+2].wdata}, 32'h156);
            check("t4_st_stable", {31'd0, acc_q[base+2].stable}, 32'd1);
        end
        check("t4_mem12", {16'd0, memval(8'h12)}, 32'h156);
        check("t4_r4_kept", {16'd0, memval(8'h00)}, 32'h156);

        // Reset asserted mid-MEM, late rvalid, then clean restart
        new_mem(); init_mem[0] = 16'd9; init_mem[9] = 16'h5555;
        ld_delay = 20;
        clear_rom(); rom[0] = 9'o410;
        start_prog();
        for (int i = 0; i < 20; i++) begin
            if (dmem_req) break;
            @(negedge Clk);
        end
        check("t5_req_seen", {31'd0, dmem_req}, 32'd1);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("t5_req_drop", {31'd0, dmem_req}, 32'd0);
        check("t5_ack", {31'd0, Ack}, 32'd0);
        check("t5_pc", {22'd0, imem_addr}, 32'd0);
        check("t5_cyc", {16'd0, CycleCt}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        late_rv = 1'b1;
        repeat (3) @(negedge Clk);
        check("t5_late_req", {31'd0, dmem_req}, 32'd0);
        check("t5_late_pc", {22'd0, imem_addr}, 32'd0);
        check("t5_late_ack", {31'd0, Ack}, 32'd0);
        late_rv = 1'b0;
        ld_delay = 0;
        base = acc_q.size();
        clear_rom(); rom[0] = 9'o420; rom[1] = 9'o552; rom[2] = 9'o700;
        start_prog();
        wait_ack("t5_done");
        check("t5_r5_cleared", {16'd0, memval(8'd9)}, 32'd0);
        if (acc_q.size() > base)
            check("t5_first_addr", {24'd0, acc_q[base].addr}, 32'd0);
        check("t5_run_cyc", {16'd0, CycleCt}, expc(12));

        // Start pulsed during EXEC of the ST is ignored (r2=9 after reset test)
        new_mem();
        clear_rom(); rom[0] = 9'o022; rom[1] = 9'o520; rom[2] = 9'o700;
        base = acc_q.size();
        start_prog();
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_ack("t6_done");
        check("t6_res", {16'd0, memval(8'd0)}, 32'd18);
        check("t6_nacc", acc_q.size() - base, 32'd1);
        check("t6_cyc", {16'd0, CycleCt}, expc(11));
        check("t6_done_pc", {22'd0, imem_addr}, 32'd2);

        // Start in DONE restarts at PC 0 with the counter cleared
        start_prog();
        check("t6_restart_pc", {22'd0, imem_addr}, 32'd0);
        check("t6_restart_ack", {31'd0, Ack}, 32'd0);
        check("t6_restart_cyc", {16'd0, CycleCt}, 32'd0);
        wait_ack("t6b_done");
        check("t6b_res", {16'd0, memval(8'd0)}, 32'd36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
